// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: reset/bubble constants and the IF/ID bundle.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: downstream control in, instruction-memory read port, IF/ID outputs.
// stall/redirect are level controls sampled at each rising edge; redirect wins over stall.
interface if_fetch_stage_if #(
    parameter int IM_AW = 10
);
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_dout;
    logic [31:0]      pc;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc_plus4;
    logic             ifid_valid;
    logic [31:0]      fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, im_dout,
        output im_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, im_dout,
        input  im_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register for the IF/ID bundle; priority is flush > hold > load.
module if_id_reg
    import cpu_pkg::ifid_t;
#(
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);
    localparam ifid_t BUBBLE = '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};

    ifid_t stage_q;
    ifid_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (!hold) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
module if_fetch_stage
    import cpu_pkg::ifid_t;
#(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter int          IM_AW     = 10
) (
    input logic               clk,
    input logic               rst,
    if_fetch_stage_if.master  bus
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic [31:0] pc_plus4;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_plus4 = pc_q + 32'd4;

    // A redirect comes from further down the pipe, so it overrides a stall.
    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc & ~32'h3;
        end else if (!bus.stall) begin
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        ifid_d.instr    = bus.im_dout;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (bus.stall),
        .flush (bus.redirect),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    // Upper PC bits are dropped here, so fetches alias within instruction memory.
    assign bus.im_addr       = pc_q[IM_AW+1:2];
    assign bus.pc            = pc_q;
    assign bus.ifid_instr    = ifid_q.instr;
    assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign bus.ifid_valid    = ifid_q.valid;
    assign bus.fetch_count   = fetch_count_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table plus randomized run vs a model.
module tb_if_fetch_stage;

  localparam int AW = 10;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  logic [31:0] imem [0:(1<<AW)-1];

  if_fetch_stage_if #(.IM_AW(AW)) bus ();

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .IM_AW     (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.im_dout = imem[bus.im_addr];

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return imem[addr[AW+1:2]];
  endfunction

  // driver: apply inputs at negedge, advance one edge, update the model
  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst             = r;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      m_pc = {rpc[31:2], 2'b00}; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = word_at(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic check_against(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pp4, input logic valid, input logic [31:0] cnt);
    chk({tag, ".pc"},       bus.pc, pc);
    chk({tag, ".im_addr"},  {22'h0, bus.im_addr}, {22'h0, pc[AW+1:2]});
    chk({tag, ".instr"},    bus.ifid_instr, instr);
    chk({tag, ".pc_plus4"}, bus.ifid_pc_plus4, pp4);
    chk({tag, ".valid"},    {31'h0, bus.ifid_valid}, {31'h0, valid});
    chk({tag, ".count"},    bus.fetch_count, cnt);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    for (int i = 0; i < (1<<AW); i++) imem[i] = 32'h1000_0000 + i;
    imem[0] = 32'h2001_000A;
    imem[1] = 32'h2002_0005;
    imem[2] = 32'h0022_1820;

    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;

    //           rst   stall redir rpc            pc             instr          pp4            v     cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h2001_000A, 32'h4,         1'b1, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'h2002_0005, 32'h8,         1'b1, 32'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,         32'h2002_0005, 32'h8,         1'b1, 32'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,         32'h2002_0005, 32'h8,         1'b1, 32'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h0022_1820, 32'hC,         1'b1, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h43,        32'h40,        32'h0,         32'h0,         1'b0, 32'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        32'h1000_0010, 32'h44,        1'b1, 32'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h20,        32'h20,        32'h0,         32'h0,         1'b0, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h24,        32'h1000_0008, 32'h24,        1'b1, 32'd5};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 32'd5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h1000_03FF, 32'h0,         1'b1, 32'd6};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h1004,      32'h1004,      32'h0,         32'h0,         1'b0, 32'd6};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h1008,      32'h2002_0005, 32'h1008,      1'b1, 32'd7};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h8,         32'h8,         32'h0,         32'h0,         1'b0, 32'd7};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h103,       32'h100,       32'h0,         32'h0,         1'b0, 32'd7};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h200,       32'h0,         32'h0,         32'h0,         1'b0, 32'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h30,        32'h30,        32'h0,         32'h0,         1'b0, 32'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h34,        32'h1000_000C, 32'h34,        1'b1, 32'd1};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      check_against($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_pp4, vecs[i].e_valid, vecs[i].e_cnt);
    end

    // hand sequence: hold stall over a redirect-target fetch, then reset while stalled
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0800);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check_against("stall_after_redirect", 32'h800, 32'h0, 32'h0, 1'b0, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_against("fetch_after_bubble", 32'h804, 32'h1000_0200, 32'h804, 1'b1, 32'd2);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_against("reset_mid_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic r, st, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      rpc = $urandom();
      drive(r, st, rd, rpc);
      check_against($sformatf("rnd%0d", i), m_pc, m_instr, m_pp4, m_valid, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
